// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous RAM (1-cycle read latency, byte
//   enables, write-first) between the core's instruction-fetch port (i_*)
//   and data port (d_*). Grants are combinational from the requests and the
//   registered arbitration state. At most one grant is issued per cycle, and
//   the winner drives mem_* in that same cycle. Read data is steered back to
//   the issuing port one cycle later.
//
//   Default arbitration: the data port wins contention, except that after
//   MAX_BURST consecutive data grants with fetch waiting, fetch wins once.
//   Define MEM_ARBITER_ROUND_ROBIN_EN to alternate the winner on contention
//   instead. In that build the streak counter and MAX_BURST are unused.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   i_req/i_addr        : fetch request (read only)
//   i_gnt/i_wait        : fetch accepted / fetch stalled
//   i_rdata/i_rvalid    : fetch response
//   d_req/d_addr/d_we/d_wdata/d_byteen : data request
//   d_gnt/d_wait        : data accepted / data stalled
//   d_rdata/d_rvalid    : load response (none for writes)
//   mem_en/mem_addr/mem_we/mem_wdata/mem_byteen : RAM command
//   mem_q               : RAM read data, valid one cycle after the read
module mem_arbiter #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_wait,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_rvalid,
   input  logic                d_req,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_we,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_byteen,
   output logic                d_gnt,
   output logic                d_wait,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_rvalid,
   output logic                mem_en,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_byteen,
   input  logic [DATA_W-1:0]   mem_q
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t resp_owner;
   logic   gnt_i, gnt_d;
   logic   i_wins;   // fetch takes priority if both request this cycle

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic last_owner;  // 0 = I, 1 = D; resets to I so D wins first contention

   assign i_wins = last_owner;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      last_owner <= 1'b0;
      else if (gnt_i) last_owner <= 1'b0;
      else if (gnt_d) last_owner <= 1'b1;
   end
`else
   logic [3:0] d_streak;  // consecutive D grants while fetch is requesting

   assign i_wins = (d_streak == 4'(MAX_BURST));

   // A fetch grant or any cycle without a fetch request (including a flush)
   // restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         d_streak <= 4'd0;
      else if (!i_req || gnt_i)
         d_streak <= 4'd0;
      else if (gnt_d && d_streak != 4'(MAX_BURST))
         d_streak <= d_streak + 4'd1;
   end
`endif

   // Grants are forced low during reset so the RAM sees no command.
   assign gnt_i = ~reset & i_req & (~d_req | i_wins);
   assign gnt_d = ~reset & d_req & ~gnt_i;

   assign i_gnt  = gnt_i;
   assign d_gnt  = gnt_d;
   assign i_wait = ~reset & i_req & ~gnt_i;
   assign d_wait = ~reset & d_req & ~gnt_d;

   assign mem_en     = gnt_i | gnt_d;
   assign mem_addr   = gnt_i ? i_addr : (gnt_d ? d_addr : '0);
   assign mem_we     = gnt_d & d_we;
   assign mem_wdata  = mem_we ? d_wdata  : '0;
   assign mem_byteen = mem_we ? d_byteen : '0;

   // Writes leave no response owner, so they never raise rvalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                resp_owner <= OWN_NONE;
      else if (gnt_i)           resp_owner <= OWN_I;
      else if (gnt_d && !d_we)  resp_owner <= OWN_D;
      else                      resp_owner <= OWN_NONE;
   end

   assign i_rvalid = (resp_owner == OWN_I);
   assign d_rvalid = (resp_owner == OWN_D);
   assign i_rdata  = reset ? '0 : mem_q;
   assign d_rdata  = reset ? '0 : mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed test of mem_arbiter against a write-first, byte-enabled RAM
//   model. Expected grant sequences are hand written per build.
module tb_mem_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt, i_wait, i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req, d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_byteen;
   logic              d_gnt, d_wait, d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_byteen;
   logic [DATA_W-1:0] mem_q;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_wait(i_wait),
      .i_rdata(i_rdata), .i_rvalid(i_rvalid),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
      .d_byteen(d_byteen), .d_gnt(d_gnt), .d_wait(d_wait),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_q(mem_q)
   );

   // Write-first single-port RAM, one-cycle read latency.
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] mw;
   always @(posedge clk) begin
      if (mem_en) begin
         mw = ram[mem_addr];
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_byteen[b]) mw[8*b +: 8] = mem_wdata[8*b +: 8];
         ram[mem_addr] <= mw;
         mem_q         <= mw;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_req = 0; d_req = 0; d_we = 0; d_byteen = 4'b0; d_wdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      cyc();
      reset = 1'b0;
   endtask

   // d_req held high (reads of 0x20), i_req per character of ireq_s,
   // expected winner per character of exp_s ('I', 'D', '-').
   task automatic run_seq(input string name, input string ireq_s, input string exp_s);
      byte prev = "-";
      byte e;
      i_addr = 14'h0010; d_addr = 14'h0020; d_we = 0;
      for (int c = 0; c < exp_s.len(); c++) begin
         i_req = (ireq_s[c] == "1");
         d_req = 1'b1;
         e     = exp_s[c];
         #2;
         chk($sformatf("%s_c%0d_ignt", name, c), i_gnt, e == "I");
         chk($sformatf("%s_c%0d_dgnt", name, c), d_gnt, e == "D");
         chk($sformatf("%s_c%0d_iwait", name, c), i_wait, i_req && e != "I");
         chk($sformatf("%s_c%0d_irv", name, c), i_rvalid, prev == "I");
         chk($sformatf("%s_c%0d_drv", name, c), d_rvalid, prev == "D");
         if (prev == "I") chk($sformatf("%s_c%0d_irdata", name, c), i_rdata, 32'hDEADBEEF);
         if (prev == "D") chk($sformatf("%s_c%0d_drdata", name, c), d_rdata, 32'h1122AB44);
         prev = e;
         cyc();
      end
      idle();
      #2;
      chk({name, "_tail_irv"}, i_rvalid, prev == "I");
      chk({name, "_tail_drv"}, d_rvalid, prev == "D");
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = '0;
      ram[14'h0010] = 32'hDEADBEEF;
      ram[14'h0020] = 32'h11223344;
      i_addr = '0; d_addr = '0;
      idle();

      // Reset: requests present but everything must stay low.
      reset = 1'b1;
      i_req = 1; d_req = 1;
      #2;
      chk("rst_ignt", i_gnt, 0);
      chk("rst_dgnt", d_gnt, 0);
      chk("rst_iwait", i_wait, 0);
      chk("rst_dwait", d_wait, 0);
      chk("rst_memen", mem_en, 0);
      chk("rst_irv", i_rvalid, 0);
      chk("rst_drv", d_rvalid, 0);
      cyc();
      idle();
      reset = 1'b0;
      cyc();

      // Single fetch.
      i_req = 1; i_addr = 14'h0010;
      #2;
      chk("fetch_ignt", i_gnt, 1);
      chk("fetch_iwait", i_wait, 0);
      chk("fetch_memen", mem_en, 1);
      chk("fetch_addr", mem_addr, 14'h0010);
      chk("fetch_we", mem_we, 0);
      chk("fetch_be", mem_byteen, 0);
      cyc();
      i_req = 0;
      #2;
      chk("fetch_irv", i_rvalid, 1);
      chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
      chk("fetch_drv", d_rvalid, 0);
      cyc();

      // Byte write then read-back.
      d_req = 1; d_we = 1; d_addr = 14'h0020; d_byteen = 4'b0010; d_wdata = 32'h0000AB00;
      #2;
      chk("wr_dgnt", d_gnt, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_be", mem_byteen, 4'b0010);
      chk("wr_wdata", mem_wdata, 32'h0000AB00);
      cyc();
      d_we = 0; d_byteen = 4'b0;
      #2;
      chk("rd_dgnt", d_gnt, 1);
      chk("rd_we", mem_we, 0);
      chk("wr_no_drv", d_rvalid, 0);
      cyc();
      idle();
      #2;
      chk("rd_drv", d_rvalid, 1);
      chk("rd_rdata", d_rdata, 32'h1122AB44);
      cyc();

      // Sustained contention from a clean arbitration state.
      do_reset();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      run_seq("cont", "1111111111", "DIDIDIDIDI");
`else
      run_seq("cont", "1111111111", "DDDDIDDDDI");
`endif
      cyc();

      // Reset arriving the cycle after a data read grant.
      d_req = 1; d_we = 0; d_addr = 14'h0020;
      #2;
      chk("rmid_dgnt", d_gnt, 1);
      cyc();
      reset = 1'b1;
      #2;
      chk("rmid_drv0", d_rvalid, 0);
      chk("rmid_drdata", d_rdata, 0);
      chk("rmid_memen", mem_en, 0);
      chk("rmid_dgnt0", d_gnt, 0);
      cyc();
      #2;
      chk("rmid_drv1", d_rvalid, 0);
      cyc();
      reset = 1'b0;
      i_req = 1; i_addr = 14'h0010;
      #2;
      chk("rmid_first_dgnt", d_gnt, 1);
      chk("rmid_first_ignt", i_gnt, 0);
      cyc();
      idle();
      cyc();

      // Fetch flushed while waiting behind data; streak must restart.
      do_reset();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      run_seq("flush", "1011111", "DDIDIDI");
`else
      run_seq("flush", "1011111", "DDDDDDI");
`endif
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
